// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg: multiply/divide opcodes, FSM states and the shared negate helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

   localparam int MD_ITER = 32;

   function automatic logic [31:0] twos_neg(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit: 34-cycle iterative MULT/MULTU/DIV/DIVU with HI/LO registers.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_div_unit
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  md_op_t      op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [4:0] LAST_ITER = 5'(MD_ITER - 1);

   md_state_t   state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
   logic [63:0] acc_q, acc_d;
   logic [31:0] opb_q, opb_d;
   logic        is_div_q, is_div_d;
   logic        neg_res_q, neg_res_d;
   logic        neg_rem_q, neg_rem_d;
   logic        div0_q, div0_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        signed_op, sign_a, sign_b;
   logic [31:0] mag_a, mag_b;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic        q_bit;
   logic [31:0] prod_lo, prod_hi, quot, rem;

   always_comb begin
      signed_op = (op == MD_MULT) || (op == MD_DIV);
      sign_a    = signed_op & operand_a[31];
      sign_b    = signed_op & operand_b[31];
      mag_a     = sign_a ? twos_neg(operand_a) : operand_a;
      mag_b     = sign_b ? twos_neg(operand_b) : operand_b;

      mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
      div_shift = acc_q[63:31];
      div_diff  = div_shift - {1'b0, opb_q};
      q_bit     = ~div_diff[32];

      prod_lo   = neg_res_q ? twos_neg(acc_q[31:0]) : acc_q[31:0];
      prod_hi   = neg_res_q ? (~acc_q[63:32] + {31'd0, (acc_q[31:0] == 32'd0)})
                            : acc_q[63:32];
      quot      = neg_res_q ? twos_neg(acc_q[31:0]) : acc_q[31:0];
      rem       = neg_rem_q ? twos_neg(acc_q[63:32]) : acc_q[63:32];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opb_d     = opb_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         MD_IDLE: begin
            if (start) begin
               case (op)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                     is_div_d  = (op == MD_DIV) || (op == MD_DIVU);
                     neg_res_d = sign_a ^ sign_b;
                     neg_rem_d = sign_a;
                     div0_d    = (operand_b == 32'd0);
                     cnt_d     = 5'd0;
                     state_d   = MD_CALC;
                     if ((op == MD_DIV) || (op == MD_DIVU)) begin
                        acc_d = {32'd0, mag_a};
                        opb_d = mag_b;
                     end else begin
                        acc_d = {32'd0, mag_b};
                        opb_d = mag_a;
                     end
                  end
                  MD_MTHI: begin
                     hi_d   = operand_a;
                     done_d = 1'b1;
                  end
                  MD_MTLO: begin
                     lo_d   = operand_a;
                     done_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end

         MD_CALC: begin
            if (is_div_q) begin
               acc_d = {(q_bit ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], q_bit};
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
               state_d = MD_FIX;
            end
         end

         MD_FIX: begin
            // With a zero divisor the remainder path already reproduces operand_a.
            if (is_div_q) begin
               lo_d = div0_q ? 32'hFFFF_FFFF : quot;
               hi_d = rem;
            end else begin
               lo_d = prod_lo;
               hi_d = prod_hi;
            end
            done_d  = 1'b1;
            state_d = MD_IDLE;
         end

         default: state_d = MD_IDLE;
      endcase

      busy_d = (state_d != MD_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= MD_IDLE;
         cnt_q     <= 5'd0;
         acc_q     <= 64'd0;
         opb_q     <= 32'd0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opb_q     <= opb_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire
